// File: rtl/cla.sv
// cla: registered two-level carry-lookahead adder built from 4-bit lookahead slices
module cla #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Pg,
  output logic             Gg,
  output logic             Ovf
);
  localparam int NS = WIDTH / 4;
  logic [WIDTH-1:0] g, p, c, sum_d, sum_q;
  logic [NS-1:0] sp, sg;
  logic [NS:0] sc;
  logic acc, pa, pg_d, gg_d, cout_d, ovf_d, pg_q, gg_q, cout_q, ovf_q;
  assign g = A & B;
  assign p = A ^ B;
  for (genvar s = 0; s < NS; s++) begin : g_slice
    logic [3:0] ps, gs;
    logic ci;
    assign ps = p[4*s +: 4];
    assign gs = g[4*s +: 4];
    assign ci = sc[s];
    assign c[4*s]   = ci;
    assign c[4*s+1] = gs[0] | (ps[0] & ci);
    assign c[4*s+2] = gs[1] | (ps[1] & gs[0]) | (ps[1] & ps[0] & ci);
    assign c[4*s+3] = gs[2] | (ps[2] & gs[1]) | (ps[2] & ps[1] & gs[0]) | (ps[2] & ps[1] & ps[0] & ci);
    assign sp[s] = &ps;
    assign sg[s] = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1]) | (ps[3] & ps[2] & ps[1] & gs[0]);
  end
  // second-level lookahead: each slice carry-in is an independent sum of products over slice P/G and Cin
  always_comb begin
    sc = '0;
    sc[0] = Cin;
    acc = 1'b0;
    pa = 1'b1;
    for (int k = 1; k <= NS; k++) begin
      acc = 1'b0;
      pa = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        acc = acc | (sg[j] & pa);
        pa = pa & sp[j];
      end
      sc[k] = acc | (pa & Cin);
    end
    gg_d = acc;
    pg_d = pa;
    cout_d = sc[NS];
    sum_d = p ^ c;
    ovf_d = (A[WIDTH-1] == B[WIDTH-1]) & (sum_d[WIDTH-1] != A[WIDTH-1]);
  end
  // output registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      pg_q   <= 1'b0;
      gg_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      pg_q   <= pg_d;
      gg_q   <= gg_d;
      ovf_q  <= ovf_d;
    end
  end
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Pg   = pg_q;
  assign Gg   = gg_q;
  assign Ovf  = ovf_q;
endmodule

// File: tb/tb_cla.sv
// tb_cla: directed vectors, exhaustive sweep and async reset checks against an arithmetic model
module tb_cla;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic cin = 1'b0;
  logic [W-1:0] sum;
  logic cout, pg, gg, ovf;
  logic [W+3:0] act, exp_q;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  always #5 clk = ~clk;
  cla #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin),
    .Sum(sum), .Cout(cout), .Pg(pg), .Gg(gg), .Ovf(ovf)
  );
  assign act = {ovf, gg, pg, cout, sum};
  // expected {Ovf,Gg,Pg,Cout,Sum} from plain integer arithmetic
  function automatic logic [W+3:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] full, gen;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    gen = {1'b0, x} + {1'b0, y};
    return {(x[W-1] == y[W-1]) && (full[W-1] != x[W-1]), gen[W], &(x ^ y), full[W], full[W-1:0]};
  endfunction
  task automatic check(input string name, input logic [W+3:0] got, input logic [W+3:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask
  // one-cycle-delayed expectation, cleared by reset like the outputs
  always @(posedge clk or negedge rst_n) exp_q <= !rst_n ? '0 : model(a, b, cin);
  always @(negedge clk) if (chk_en) check("stream", act, exp_q);
  task automatic vec(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic [W+3:0] want);
    @(negedge clk);
    #1;
    a = x;
    b = y;
    cin = ci;
    @(posedge clk);
    #1;
    check("vec_dut", act, want);
    check("vec_model", exp_q, want);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset", act, '0);
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    vec(4'h0, 4'h0, 1'b0, 8'h00);
    vec(4'h1, 4'h2, 1'b0, 8'h03);
    vec(4'hE, 4'h6, 1'b0, 8'h54);
    vec(4'hF, 4'hF, 1'b0, 8'h5E);
    vec(4'hF, 4'h0, 1'b1, 8'h30);
    vec(4'h7, 4'h1, 1'b0, 8'h88);
    vec(4'hF, 4'h1, 1'b0, 8'h50);
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      #1;
      a = W'(i);
      b = W'(i >> 4);
      cin = i[8];
      if (i == 200) begin
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", act, '0);
      end
      if (i == 203) begin
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release", {3'b000, act[W:0]}, {3'b000, 5'({1'b0, a} + {1'b0, b} + {4'b0, cin})});
      end
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cla.md
CLA -- requirements
Module: cla

Interface
REQ-001 Parameter WIDTH, default 4: operand and sum width in bits; SHALL be a multiple of 4 in the range 4..32.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port A, input, WIDTH bits: unsigned/two's-complement operand A.
REQ-005 Port B, input, WIDTH bits: operand B.
REQ-006 Port Cin, input, 1 bit: carry-in.
REQ-007 Port Sum, output, WIDTH bits: registered sum, A+B+Cin modulo 2^WIDTH.
REQ-008 Port Cout, output, 1 bit: registered carry-out of bit WIDTH-1.
REQ-009 Port Pg, output, 1 bit: registered group propagate, AND of all bit propagates (A^B).
REQ-010 Port Gg, output, 1 bit: registered group generate, carry-out of the add with Cin forced to 0.
REQ-011 Port Ovf, output, 1 bit: registered signed overflow flag.

Function
REQ-012 Per-bit terms: g[i]=A[i]&B[i], p[i]=A[i]^B[i].
REQ-013 Each 4-bit slice SHALL compute its internal carries by lookahead equations from its p, g and slice carry-in, with no bit-to-bit ripple.
REQ-014 Each slice SHALL produce a slice propagate (AND of its four p) and a slice generate (g3|p3g2|p3p2g1|p3p2p1g0).
REQ-015 Slice carry-ins SHALL come from a second-level lookahead over slice P/G and Cin; no slice-to-slice ripple chain.
REQ-016 Sum[i] = p[i] ^ c[i], where c[0]=Cin.
REQ-017 Cout = c[WIDTH]; {Cout,Sum} SHALL equal A+B+Cin as an unsigned (WIDTH+1)-bit value for all inputs.
REQ-018 Ovf = (A[MSB]==B[MSB]) & (Sum[MSB]!=A[MSB]), computed from the combinational sum.
REQ-019 Pg and Gg SHALL be the top-level lookahead P and G; Cout SHALL equal Gg|(Pg&Cin).
REQ-020 All outputs SHALL be registered on the rising clk edge. Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-021 A new operand set SHALL be accepted every cycle; there is no handshake and no stall.
REQ-022 The combinational path SHALL complete within one clock period. No multicycle path is permitted.
REQ-023 Wrap-around: all-ones + 1 (via B or Cin) SHALL give Sum=0 and Cout=1.
REQ-024 Cin SHALL be fully general; no special-casing of zero operands.

Reset
REQ-025 rst_n low SHALL immediately (asynchronously) force Sum=0, Cout=0, Pg=0, Gg=0, Ovf=0, independent of clk.
REQ-026 While rst_n is low, outputs SHALL hold 0 and inputs SHALL be ignored.
REQ-027 Deassertion is synchronous to the next clk rising edge. The first edge with rst_n high SHALL register the current inputs.
REQ-028 Reset asserted mid-stream SHALL discard any result in flight; no stale result appears after release.

Verification (WIDTH=4; results checked one cycle after the inputs are applied)
REQ-029 A=0000, B=0000, Cin=0 -> Sum=0000, Cout=0, Pg=0, Gg=0, Ovf=0.
REQ-030 A=0001, B=0010, Cin=0 -> Sum=0011, Cout=0.
REQ-031 A=1110, B=0110, Cin=0 -> Sum=0100, Cout=1, Ovf=0. A=1111, B=1111, Cin=0 -> Sum=1110, Cout=1, Gg=1.
REQ-032 A=1111, B=0000, Cin=1 -> Sum=0000, Cout=1, Pg=1, Gg=0. A=0111, B=0001, Cin=0 -> Sum=1000, Ovf=1.
REQ-033 Exhaustive sweep of all 512 (A,B,Cin) combinations, back-to-back, one per cycle -> each {Cout,Sum} equals A+B+Cin one cycle later.
REQ-034 Assert rst_n between clk edges during the sweep -> all outputs 0 at once. Release -> the first result is from the inputs present at the first edge after release.
